// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// next-PC select codes and the default instruction memory size.
package fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_VALID = 3'd2,
      S_EXEC  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JR     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam int unsigned MEM_BYTES_DEFAULT = 128;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection: sequential, word-offset branch,
// register jump and region-relative absolute jump.
module next_pc_mux
   import fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_src,
   input  logic [31:0] imm,
   input  logic [31:0] reg_addr,
   input  logic [25:0] j_addr,
   output logic [31:0] next_pc
);

   logic [31:0] pc4;

   always_comb begin
      pc4 = pc + 32'd4;
      unique case (pc_src)
         PC_NEXT:   next_pc = pc4;
         PC_BRANCH: next_pc = pc4 + (imm << 2);
         PC_JR:     next_pc = reg_addr;
         PC_JUMP:   next_pc = {pc4[31:28], j_addr, 2'b00};
         default:   next_pc = pc4;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-cycle fetch, IR handshake with decode,
// PC update on PCWre with illegal-target detection and halt handling.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        PCWre,
   input  logic [1:0]  PCSrc,
   input  logic [31:0] Imm,
   input  logic [31:0] RegAddr,
   input  logic [25:0] JAddr,
   input  logic        Halt,
   input  logic        ir_ready,
   input  logic [31:0] InsData,
   output logic [31:0] IAddr,
   output logic        RW,
   output logic [31:0] PC,
   output logic [31:0] IR,
   output logic        ir_valid,
   output logic        AddrErr
);

   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

   state_t      state, state_nxt;
   logic [31:0] next_pc;
   logic [31:0] iaddr_q;
   logic        target_bad;

   next_pc_mux u_next_pc_mux (
      .pc       (PC),
      .pc_src   (PCSrc),
      .imm      (Imm),
      .reg_addr (RegAddr),
      .j_addr   (JAddr),
      .next_pc  (next_pc)
   );

   assign target_bad = (next_pc[1:0] != 2'b00) || (next_pc > LAST_WORD);

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: state_nxt = Halt ? S_HALT : S_VALID;
         S_VALID: begin
            if (Halt)          state_nxt = S_HALT;
            else if (ir_ready) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (Halt)       state_nxt = S_HALT;
            else if (PCWre) state_nxt = target_bad ? S_HALT : S_FETCH;
         end
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ir_valid is exactly "in S_VALID": set by the fetch edge, cleared on
   // accept or halt, so it needs no register of its own.
   always_comb begin
      RW       = (state == S_FETCH);
      ir_valid = (state == S_VALID);
      IAddr    = (state == S_FETCH) ? PC : iaddr_q;
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         PC      <= RESET_PC;
         iaddr_q <= RESET_PC;
         IR      <= '0;
         AddrErr <= 1'b0;
      end else begin
         if (state == S_FETCH) begin
            iaddr_q <= PC;
            if (!Halt) IR <= InsData;
         end
         if (state == S_EXEC && !Halt && PCWre) begin
            if (target_bad) AddrErr <= 1'b1;
            else            PC      <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch handshake, PC sources, address
// errors, halt priority and asynchronous reset.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        Reset;
   logic        PCWre;
   logic [1:0]  PCSrc;
   logic [31:0] Imm;
   logic [31:0] RegAddr;
   logic [25:0] JAddr;
   logic        Halt;
   logic        ir_ready;
   logic [31:0] InsData;
   logic [31:0] IAddr;
   logic        RW;
   logic [31:0] PC;
   logic [31:0] IR;
   logic        ir_valid;
   logic        AddrErr;

   int pass_cnt = 0;
   int total    = 0;

   fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_BYTES(128)) dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .PCWre    (PCWre),
      .PCSrc    (PCSrc),
      .Imm      (Imm),
      .RegAddr  (RegAddr),
      .JAddr    (JAddr),
      .Halt     (Halt),
      .ir_ready (ir_ready),
      .InsData  (InsData),
      .IAddr    (IAddr),
      .RW       (RW),
      .PC       (PC),
      .IR       (IR),
      .ir_valid (ir_valid),
      .AddrErr  (AddrErr)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // From S_FETCH, walk through S_VALID into S_EXEC.
   task automatic to_exec();
      ir_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic pc_step(input logic [1:0] src, input logic [31:0] imm_v,
                          input logic [31:0] reg_v, input logic [25:0] j_v);
      PCSrc   = src;
      Imm     = imm_v;
      RegAddr = reg_v;
      JAddr   = j_v;
      PCWre   = 1'b1;
      tick();
      PCWre   = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; PCWre = 1'b0; PCSrc = 2'b00; Imm = '0; RegAddr = '0;
      JAddr = '0; Halt = 1'b0; ir_ready = 1'b0; InsData = '0;
      #1;
      check("rst_pc", PC, 32'h0);
      check("rst_iaddr", IAddr, 32'h0);
      check("rst_ir", IR, 32'h0);
      check("rst_valid", {31'b0, ir_valid}, 32'h0);
      check("rst_rw", {31'b0, RW}, 32'h0);
      check("rst_err", {31'b0, AddrErr}, 32'h0);

      tick(); tick();
      Reset = 1'b1;
      InsData = 32'h2001_0005;
      ir_ready = 1'b1;
      check("idle_rw", {31'b0, RW}, 32'h0);
      tick();
      check("fetch_rw", {31'b0, RW}, 32'h1);
      check("fetch_iaddr", IAddr, 32'h0);
      tick();
      check("valid_ir", IR, 32'h2001_0005);
      check("valid_flag", {31'b0, ir_valid}, 32'h1);
      check("valid_rw", {31'b0, RW}, 32'h0);
      tick();
      check("exec_valid", {31'b0, ir_valid}, 32'h0);

      InsData = 32'h1111_2222;
      pc_step(2'b00, '0, '0, '0);
      check("seq_pc", PC, 32'h4);
      check("seq_iaddr", IAddr, 32'h4);
      check("seq_rw", {31'b0, RW}, 32'h1);
      ir_ready = 1'b0;
      tick();
      check("stall_ir0", IR, 32'h1111_2222);

      InsData = 32'hDEAD_BEEF;
      PCWre = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", {31'b0, ir_valid}, 32'h1);
         check("stall_ir", IR, 32'h1111_2222);
         check("stall_rw", {31'b0, RW}, 32'h0);
         check("stall_pc", PC, 32'h4);
      end
      PCWre = 1'b0;
      ir_ready = 1'b1;
      tick();
      check("accept_valid", {31'b0, ir_valid}, 32'h0);
      pc_step(2'b00, '0, '0, '0);
      check("seq2_pc", PC, 32'h8);

      to_exec();
      pc_step(2'b01, 32'hFFFF_FFFE, '0, '0);
      check("br_pc", PC, 32'h4);
      check("br_iaddr", IAddr, 32'h4);
      check("br_rw", {31'b0, RW}, 32'h1);

      to_exec();
      pc_step(2'b11, '0, '0, 26'h4);
      check("j_pc10", PC, 32'h10);
      to_exec();
      pc_step(2'b11, '0, '0, 26'h3);
      check("j_pc0c", PC, 32'h0C);
      to_exec();
      pc_step(2'b10, '0, 32'h7C, '0);
      check("jr_last_word", PC, 32'h7C);
      check("jr_last_err", {31'b0, AddrErr}, 32'h0);
      to_exec();
      pc_step(2'b10, '0, 32'h10, '0);
      check("jr_pc10", PC, 32'h10);
      to_exec();
      pc_step(2'b10, '0, 32'h7E, '0);
      check("err_pc", PC, 32'h10);
      check("err_flag", {31'b0, AddrErr}, 32'h1);
      check("err_rw", {31'b0, RW}, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("halt_rw", {31'b0, RW}, 32'h0);
         check("halt_err", {31'b0, AddrErr}, 32'h1);
         check("halt_pc", PC, 32'h10);
      end

      #2 Reset = 1'b0;
      #1;
      check("rst2_err", {31'b0, AddrErr}, 32'h0);
      check("rst2_pc", PC, 32'h0);
      Reset = 1'b1;
      tick();
      to_exec();
      pc_step(2'b00, '0, '0, '0);
      check("seq3_pc", PC, 32'h4);
      to_exec();
      Halt = 1'b1;
      pc_step(2'b10, '0, 32'h40, '0);
      Halt = 1'b0;
      check("hp_pc", PC, 32'h4);
      check("hp_valid", {31'b0, ir_valid}, 32'h0);
      check("hp_rw", {31'b0, RW}, 32'h0);
      check("hp_err", {31'b0, AddrErr}, 32'h0);
      tick(); tick();
      check("hp_stay_rw", {31'b0, RW}, 32'h0);
      check("hp_stay_pc", PC, 32'h4);

      #2 Reset = 1'b0;
      #1 Reset = 1'b1;
      check("resume_pc", PC, 32'h0);
      InsData = 32'hCAFE_0001;
      tick();
      check("resume_rw", {31'b0, RW}, 32'h1);
      check("resume_iaddr", IAddr, 32'h0);

      to_exec();
      pc_step(2'b00, '0, '0, '0);
      check("mid_rw_pre", {31'b0, RW}, 32'h1);
      check("mid_iaddr_pre", IAddr, 32'h4);
      #2 Reset = 1'b0;
      #1;
      check("mid_rw", {31'b0, RW}, 32'h0);
      check("mid_pc", PC, 32'h0);
      check("mid_iaddr", IAddr, 32'h0);
      check("mid_ir", IR, 32'h0);
      check("mid_valid", {31'b0, ir_valid}, 32'h0);
      check("mid_err", {31'b0, AddrErr}, 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
